// File: rtl/dice_pkg.sv
// Shared definitions for the electronic-dice blocks: FSM states, throw limits
// and the 7-LED pip patterns with their decode function.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        SETTLE  = 2'd2,
        VALID   = 2'd3
    } state_t;

    localparam logic [2:0] THROW_MIN = 3'd1;
    localparam logic [2:0] THROW_MAX = 3'd6;

    // Bit order [6:0] = BR BL MR C ML TR TL
    localparam logic [6:0] PIP_OFF = 7'b0000000;
    localparam logic [6:0] PIP_1   = 7'b0001000;
    localparam logic [6:0] PIP_2   = 7'b1000001;
    localparam logic [6:0] PIP_3   = 7'b1001001;
    localparam logic [6:0] PIP_4   = 7'b1100011;
    localparam logic [6:0] PIP_5   = 7'b1101011;
    localparam logic [6:0] PIP_6   = 7'b1110111;

    function automatic logic is_bad_throw(input logic [2:0] t);
        return (t < THROW_MIN) || (t > THROW_MAX);
    endfunction

    function automatic logic [6:0] pip_decode(input logic [2:0] t);
        case (t)
            3'd1:    return PIP_1;
            3'd2:    return PIP_2;
            3'd3:    return PIP_3;
            3'd4:    return PIP_4;
            3'd5:    return PIP_5;
            3'd6:    return PIP_6;
            default: return PIP_OFF;
        endcase
    endfunction

endpackage

// File: rtl/dice_result_receiver_if.sv
// Valid/ready result channel from the dice result receiver to the
// display/scoring logic.
interface dice_result_receiver_if;

    logic       result_valid;
    logic [2:0] result_value;
    logic       bad_throw;
    logic       result_ready;

    modport master (
        output result_valid,
        output result_value,
        output bad_throw,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_value,
        input  bad_throw,
        output result_ready
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser for asynchronous inputs such as buttons.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops sample
    // their inputs from the same edge and form a true two-stage pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dice_result_receiver.sv
// Consumer end of the electronic dice: waits for the roll button to be released
// and the throw to settle, captures it and offers it on a valid/ready channel.
module dice_result_receiver
    import dice_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   button,
    input  logic [2:0]             throw,
    dice_result_receiver_if.master res,
    output logic [6:0]             pips,
    output logic [CNT_W-1:0]       roll_count
);

    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

    logic           btn_s;
    state_t         state;
    logic [SCW-1:0] settle_cnt;
    logic           result_valid;
    logic [2:0]     result_value;
    logic           bad_throw;

    sync_2ff u_btn_sync (
        .clk (clk),
        .rst (rst),
        .d   (button),
        .q   (btn_s)
    );

    assign res.result_valid = result_valid;
    assign res.result_value = result_value;
    assign res.bad_throw    = bad_throw;

    // Button activity in VALID is ignored so a pending result is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            result_valid <= 1'b0;
            result_value <= '0;
            bad_throw    <= 1'b0;
            pips         <= PIP_OFF;
            roll_count   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (btn_s) state <= ROLLING;
                end
                ROLLING: begin
                    if (!btn_s) begin
                        state      <= SETTLE;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (btn_s) begin
                        state      <= ROLLING;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        result_value <= throw;
                        bad_throw    <= is_bad_throw(throw);
                        pips         <= pip_decode(throw);
                        result_valid <= 1'b1;
                        state        <= VALID;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                VALID: begin
                    if (res.result_ready) begin
                        result_valid <= 1'b0;
                        if (!bad_throw && (roll_count != '1))
                            roll_count <= roll_count + 1'b1;
                        state <= btn_s ? ROLLING : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
